// File: rtl/nes_joypad_port.sv
// nes_joypad_port: CPU-bus responder for the two NES controller ports at $4016/$4017.
// A strobe write to $4016 latches the synchronized button levels. Each read access then
// returns one button bit on cpu_rdata[0], A first; bits [7:1] return the open-bus value.
// Ports: clk/rst (async active-low); cpu_addr/cpu_rd/cpu_wr/cpu_wdata from the 6502 core;
// cpu_rdata/cpu_rdata_valid (registered, one-cycle latency); pad1/pad2_buttons are raw levels.
module nes_joypad_port #(
  parameter logic [7:0] OPEN_BUS    = 8'h40,
  parameter int         SYNC_STAGES = 2,
  parameter logic       FILL_BIT    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdata_valid,
  input  logic [7:0]  pad1_buttons,
  input  logic [7:0]  pad2_buttons
);

  // Button synchronizers: stage 0 samples the pins, the last stage feeds the shift registers.
  logic [SYNC_STAGES-1:0][7:0] sync1_q, sync1_d;
  logic [SYNC_STAGES-1:0][7:0] sync2_q, sync2_d;

  logic       strobe_q, strobe_d;
  logic [7:0] sr1_q, sr1_d;
  logic [7:0] sr2_q, sr2_d;
  logic [7:0] rdata_q, rdata_d;
  logic       valid_q, valid_d;
  logic       rd_prev_q, rd_prev_d;
  // Cleared by reset and set once cpu_rd has been seen low, so a read that is
  // still asserted when reset releases is not taken as a new access.
  logic       rd_armed_q, rd_armed_d;

  logic       hit_4016, hit_4017;
  logic       wr_strobe;
  logic       rd_start;
  logic [7:0] pad1_sync, pad2_sync;
  logic       unused_wdata;

  assign unused_wdata = ^cpu_wdata[7:1];

  assign pad1_sync = sync1_q[SYNC_STAGES-1];
  assign pad2_sync = sync2_q[SYNC_STAGES-1];

  assign hit_4016  = (cpu_addr == 16'h4016);
  assign hit_4017  = (cpu_addr == 16'h4017);
  // $4017 writes belong to the APU frame counter, so only $4016 drives the strobe.
  assign wr_strobe = cpu_wr && hit_4016;
  // A write in the same cycle wins over the read.
  assign rd_start  = cpu_rd && !rd_prev_q && rd_armed_q && !cpu_wr && (hit_4016 || hit_4017);

  always_comb begin
    sync1_d    = sync1_q;
    sync2_d    = sync2_q;
    sync1_d[0] = pad1_buttons;
    sync2_d[0] = pad2_buttons;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync1_d[i] = sync1_q[i-1];
      sync2_d[i] = sync2_q[i-1];
    end
  end

  always_comb begin
    strobe_d   = wr_strobe ? cpu_wdata[0] : strobe_q;
    rd_prev_d  = cpu_rd;
    rd_armed_d = rd_armed_q || !cpu_rd;
    valid_d    = rd_start;
    rdata_d    = rdata_q;
    sr1_d      = sr1_q;
    sr2_d      = sr2_q;

    if (rd_start) begin
      rdata_d = {OPEN_BUS[7:1], (hit_4016 ? sr1_q[0] : sr2_q[0])};
    end

    // While strobe is high the reload dominates any read, so the registers never
    // shift and a read returns the live A bit. The reload on the 1->0 write edge
    // is the value held afterwards.
    if (strobe_q) begin
      sr1_d = pad1_sync;
      sr2_d = pad2_sync;
    end else if (rd_start) begin
      if (hit_4016) begin
        sr1_d = {FILL_BIT, sr1_q[7:1]};
      end else begin
        sr2_d = {FILL_BIT, sr2_q[7:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      strobe_q   <= 1'b0;
      sr1_q      <= 8'h00;
      sr2_q      <= 8'h00;
      rdata_q    <= 8'h00;
      valid_q    <= 1'b0;
      rd_prev_q  <= 1'b0;
      rd_armed_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      strobe_q   <= strobe_d;
      sr1_q      <= sr1_d;
      sr2_q      <= sr2_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
      rd_prev_q  <= rd_prev_d;
      rd_armed_q <= rd_armed_d;
    end
  end

  assign cpu_rdata       = rdata_q;
  assign cpu_rdata_valid = valid_q;

endmodule

// File: tb/tb_nes_joypad_port.sv
module tb_nes_joypad_port;

  localparam int         SS      = 2;
  localparam logic [6:0] OB_HI   = 7'h20;  // OPEN_BUS 8'h40 bits [7:1]
  localparam logic       FILL    = 1'b1;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdata_valid;
  logic [7:0]  pad1_buttons;
  logic [7:0]  pad2_buttons;

  nes_joypad_port #(
    .OPEN_BUS(8'h40),
    .SYNC_STAGES(SS),
    .FILL_BIT(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_addr(cpu_addr),
    .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_rdata_valid(cpu_rdata_valid),
    .pad1_buttons(pad1_buttons),
    .pad2_buttons(pad2_buttons)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: latched controller byte per port plus how many bits were read.
  logic       m_strobe;
  logic [7:0] m_lat [2];
  int         m_idx [2];
  logic [7:0] pad_v [2];

  logic [7:0] exp_q[$];
  logic [7:0] last_exp;
  int         checks;
  int         errors;

  // Monitor: pops an expectation on every valid pulse, checks hold and reset otherwise.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (cpu_rdata !== 8'h00 || cpu_rdata_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: rdata=%h valid=%b required rdata=00 valid=0",
                 cpu_rdata, cpu_rdata_valid);
      end
      last_exp = 8'h00;
    end else if (cpu_rdata_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: rdata=%h with no access outstanding", cpu_rdata);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        last_exp = e;
        if (cpu_rdata !== e) begin
          errors++;
          $display("FAIL read_data: got %h required %h", cpu_rdata, e);
        end
      end
    end else begin
      checks++;
      if (cpu_rdata !== last_exp || cpu_rdata_valid !== 1'b0) begin
        errors++;
        $display("FAIL rdata_hold: got %h valid=%b required %h valid=0",
                 cpu_rdata, cpu_rdata_valid, last_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_strobe = 1'b0;
    m_lat[0] = 8'h00;
    m_lat[1] = 8'h00;
    m_idx[0] = 0;
    m_idx[1] = 0;
  endtask

  task automatic set_pads(input logic [7:0] a, input logic [7:0] b);
    pad1_buttons = a;
    pad2_buttons = b;
    pad_v[0] = a;
    pad_v[1] = b;
    repeat (SS + 2) tick();
  endtask

  task automatic model_write(input logic [15:0] addr, input logic [7:0] data);
    if (addr == 16'h4016) begin
      if (m_strobe && !data[0]) begin
        m_lat[0] = pad_v[0];
        m_lat[1] = pad_v[1];
        m_idx[0] = 0;
        m_idx[1] = 0;
      end
      m_strobe = data[0];
    end
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
    model_write(addr, data);
    cpu_addr  = addr;
    cpu_wdata = data;
    cpu_wr    = 1'b1;
    tick();
    cpu_wr    = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [15:0] addr, input int hold);
    if (addr == 16'h4016 || addr == 16'h4017) begin
      int   p;
      logic b;
      p = (addr == 16'h4016) ? 0 : 1;
      if (m_strobe) begin
        b = pad_v[p][0];
      end else if (m_idx[p] < 8) begin
        b = m_lat[p][m_idx[p]];
        m_idx[p]++;
      end else begin
        b = FILL;
      end
      exp_q.push_back({OB_HI, b});
    end
    cpu_addr = addr;
    cpu_rd   = 1'b1;
    repeat (hold) tick();
    cpu_rd   = 1'b0;
    tick();
  endtask

  task automatic latch();
    do_write(16'h4016, 8'h01);
    do_write(16'h4016, 8'h00);
  endtask

  task automatic drain_check(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_valid: %0d reads got no valid pulse, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    last_exp = 8'h00;
    rst       = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_wdata = 8'h00;
    pad1_buttons = 8'h00;
    pad2_buttons = 8'h00;
    pad_v[0] = 8'h00;
    pad_v[1] = 8'h00;
    model_reset();

    // Reset with bus and button activity.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      cpu_addr     = (i % 2 == 0) ? 16'h4016 : 16'h4017;
      cpu_rd       = 1'($urandom);
      cpu_wr       = 1'($urandom);
      cpu_wdata    = 8'($urandom);
      pad1_buttons = 8'($urandom);
      pad2_buttons = 8'($urandom);
    end
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    rst    = 1'b1;
    set_pads(8'h00, 8'h00);
    do_read(16'h4016, 1);          // strobe=0, register cleared -> 8'h40
    drain_check("reset_read");

    // Basic serial read, with fill bits after the eighth access.
    set_pads(8'b1000_0101, 8'h3C);
    latch();
    for (int i = 0; i < 10; i++) do_read(16'h4016, 1);
    drain_check("serial");

    // Held read: one access, one shift.
    set_pads(8'b0000_0010, 8'h00);
    latch();
    do_read(16'h4016, 5);
    do_read(16'h4016, 1);          // B
    drain_check("held");

    // Strobe held high: live A, no shifting on either port.
    set_pads(8'h5A, 8'hC3);
    latch();
    do_read(16'h4017, 1);
    do_write(16'h4016, 8'h01);
    set_pads(8'h01, 8'hC3);
    do_read(16'h4016, 1);
    do_read(16'h4016, 2);
    set_pads(8'h00, 8'hC3);
    do_read(16'h4016, 1);
    set_pads(8'h01, 8'hC3);
    do_read(16'h4016, 1);
    do_write(16'h4016, 8'h00);
    for (int i = 0; i < 3; i++) do_read(16'h4017, 1);
    drain_check("strobe_high");

    // Port independence.
    set_pads(8'hFF, 8'h00);
    latch();
    for (int i = 0; i < 9; i++) begin
      do_read(16'h4016, 1);
      do_read(16'h4017, 1 + (i % 2));
    end
    drain_check("ports");

    // Write/read collision on $4016 sets strobe, no read start.
    set_pads(8'h01, 8'h00);
    model_write(16'h4016, 8'h01);
    cpu_addr  = 16'h4016;
    cpu_wdata = 8'h01;
    cpu_wr    = 1'b1;
    cpu_rd    = 1'b1;
    tick();
    cpu_wr    = 1'b0;
    tick();
    cpu_rd    = 1'b0;
    tick();
    do_read(16'h4016, 1);          // strobe=1 -> live A=1
    do_write(16'h4016, 8'h00);
    drain_check("collision");

    // Reset mid-sequence, with a read still asserted across release.
    set_pads(8'b0110_1001, 8'hA5);
    latch();
    for (int i = 0; i < 3; i++) do_read(16'h4016, 1);
    drain_check("pre_reset");
    @(posedge clk); #1;
    rst      = 1'b0;
    cpu_addr = 16'h4016;
    cpu_rd   = 1'b1;
    model_reset();
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    cpu_rd = 1'b0;
    tick();
    latch();
    for (int i = 0; i < 9; i++) do_read(16'h4016, 1);
    drain_check("post_reset");

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      int op;
      op = $urandom_range(0, 11);
      if (op <= 5) begin
        do_read(($urandom_range(0, 1) == 0) ? 16'h4016 : 16'h4017, $urandom_range(1, 4));
      end else if (op == 6 || op == 7) begin
        do_write(16'h4016, 8'($urandom));
      end else if (op == 8) begin
        set_pads(8'($urandom), 8'($urandom));
      end else if (op == 9) begin
        do_write(16'h4017, 8'($urandom));
      end else begin
        logic [15:0] a;
        a = 16'($urandom);
        if (a == 16'h4016 || a == 16'h4017) a = 16'h4018;
        if (op == 10) do_read(a, $urandom_range(1, 3));
        else          do_write(a, 8'($urandom));
      end
    end
    drain_check("random");

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
